// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 registered demultiplexer and its sibling mux.
// Channel index constants let benches name lanes instead of using raw numbers.
package demux_pkg;

  localparam int NumChannels = 8;
  localparam int SelWidth    = 3;
  localparam int CountWidth  = 16;

  typedef logic [SelWidth-1:0] sel_t;

  localparam sel_t CH_A = 3'd0;
  localparam sel_t CH_B = 3'd1;
  localparam sel_t CH_C = 3'd2;
  localparam sel_t CH_D = 3'd3;
  localparam sel_t CH_E = 3'd4;
  localparam sel_t CH_F = 3'd5;
  localparam sel_t CH_G = 3'd6;
  localparam sel_t CH_H = 3'd7;

  // A slot's state is exactly its valid flag, so the encoding is fixed at one bit.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [NumChannels-1:0] sel_decode(input sel_t sel);
    logic [NumChannels-1:0] w_onehot;
    w_onehot      = '0;
    w_onehot[sel] = 1'b1;
    return w_onehot;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding register for one output channel.
// load may coincide with consume on a FULL slot: the word is replaced in place.
module demux_slot #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             consume_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o
);
  import demux_pkg::*;

  slot_state_e r_state;
  slot_state_e w_state_next;
  logic [Width-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SLOT_EMPTY: if (load_i) w_state_next = SLOT_FULL;
      SLOT_FULL:  if (consume_i && !load_i) w_state_next = SLOT_EMPTY;
      default:    w_state_next = SLOT_EMPTY;
    endcase
  end

  // Data keeps its last value after consumption; valid_o alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_data <= '0;
    end else if (load_i) begin
      r_data <= data_i;
    end
  end

  always_comb begin
    valid_o = (r_state == SLOT_FULL);
    data_o  = r_data;
  end

endmodule

// File: rtl/demux8_16.sv
// Registered 1-to-8 demultiplexer with per-channel single-entry slots.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module demux8_16 #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       sel_i,
  input  logic [Width-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [Width-1:0] a_o,
  output logic [Width-1:0] b_o,
  output logic [Width-1:0] c_o,
  output logic [Width-1:0] d_o,
  output logic [Width-1:0] e_o,
  output logic [Width-1:0] f_o,
  output logic [Width-1:0] g_o,
  output logic [Width-1:0] h_o,
  output logic [7:0]       valid_o,
  input  logic [7:0]       ready_i,
  output logic [15:0]      count_o
);
  import demux_pkg::*;

  logic                   w_accept;
  logic [NumChannels-1:0] w_load;
  logic [NumChannels-1:0] w_consume;
  logic [NumChannels-1:0] w_valid;
  logic [Width-1:0]       w_data [NumChannels];
  logic [CountWidth-1:0]  r_count;

  // ready_o deliberately ignores valid_i so there is no valid-to-ready loop.
  assign ready_o   = !w_valid[sel_i] || ready_i[sel_i];
  assign w_accept  = valid_i && ready_o;
  assign w_load    = w_accept ? sel_decode(sel_i) : '0;
  assign w_consume = w_valid & ready_i;

  for (genvar g = 0; g < NumChannels; g++) begin : g_slot
    demux_slot #(.Width(Width)) u_slot (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (w_load[g]),
      .consume_i (w_consume[g]),
      .data_i    (data_i),
      .data_o    (w_data[g]),
      .valid_o   (w_valid[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CountWidth'(1);
    end
  end

  assign valid_o = w_valid;
  assign count_o = r_count;
  assign a_o     = w_data[CH_A];
  assign b_o     = w_data[CH_B];
  assign c_o     = w_data[CH_C];
  assign d_o     = w_data[CH_D];
  assign e_o     = w_data[CH_E];
  assign f_o     = w_data[CH_F];
  assign g_o     = w_data[CH_G];
  assign h_o     = w_data[CH_H];

endmodule

// File: tb/tb_demux8_16.sv
// Bench for demux8_16: directed scenarios plus random traffic, checked by a
// per-channel expected-word scoreboard driven from a queue-based reference model.
module tb_demux8_16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  sel_i;
  logic [15:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o;
  logic [7:0]  valid_o;
  logic [7:0]  ready_i;
  logic [15:0] count_o;

  demux8_16 dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sel_i   (sel_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_o     (a_o),
    .b_o     (b_o),
    .c_o     (c_o),
    .d_o     (d_o),
    .e_o     (e_o),
    .f_o     (f_o),
    .g_o     (g_o),
    .h_o     (h_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Words delivered to a channel and not yet taken by its consumer.
  logic [15:0] exp_q [8][$];
  logic [15:0] last_word [8];
  logic [15:0] exp_count = 16'd0;
  bit          mon_en = 1'b0;
  bit          last_accept = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] chan(input int n);
    case (n)
      0: return a_o;
      1: return b_o;
      2: return c_o;
      3: return d_o;
      4: return e_o;
      5: return f_o;
      6: return g_o;
      default: return h_o;
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk_i) begin
    if (mon_en) begin
      logic        exp_rdy;
      logic [15:0] w;
      exp_rdy = (exp_q[sel_i].size() == 0) || ready_i[sel_i];
      check("ready_o", ready_o, exp_rdy);
      check("count_o", count_o, exp_count);
      for (int n = 0; n < 8; n++) begin
        check($sformatf("valid_o[%0d]", n), valid_o[n], exp_q[n].size() != 0);
        check($sformatf("data ch%0d", n), chan(n), last_word[n]);
      end
      if (!rst_i) begin
        for (int n = 0; n < 8; n++) begin
          exp_q[n].delete();
          last_word[n] = 16'h0000;
        end
        exp_count   = 16'd0;
        last_accept = 1'b0;
      end else begin
        for (int n = 0; n < 8; n++) begin
          if (exp_q[n].size() != 0 && ready_i[n]) begin
            w = exp_q[n].pop_front();
            check($sformatf("consumed ch%0d", n), chan(n), w);
          end
        end
        last_accept = valid_i && exp_rdy;
        if (last_accept) begin
          exp_q[sel_i].push_back(data_i);
          last_word[sel_i] = data_i;
          exp_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [15:0] d,
                       input logic [7:0] r);
    step();
    valid_i = v;
    sel_i   = s;
    data_i  = d;
    ready_i = r;
  endtask

  task automatic reset_dut();
    step();
    rst_i   = 1'b0;
    valid_i = 1'b0;
    step();
    rst_i   = 1'b1;
  endtask

  task automatic drive_random();
    step();
    if (!(valid_i && !last_accept)) begin
      valid_i = ($urandom_range(0, 3) != 0);
      sel_i   = 3'($urandom_range(0, 7));
      data_i  = 16'($urandom);
    end
    ready_i = 8'($urandom) | 8'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b0; valid_i = 1'b0; sel_i = 3'd0; data_i = 16'h0; ready_i = 8'hFF;
    for (int n = 0; n < 8; n++) last_word[n] = 16'h0000;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    mon_en = 1'b1;

    @(negedge clk_i);
    check("reset valid_o", valid_o, 8'h00);
    check("reset count_o", count_o, 16'h0000);
    check("reset ready_o", ready_o, 1'b1);
    check("reset h_o", h_o, 16'h0000);

    // one word per channel
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 8'hFF);
    drive(1'b0, 3'd0, 16'h0, 8'hFF);
    @(negedge clk_i);
    check("t1 count_o", count_o, 16'd8);
    check("t1 h_o", h_o, 16'h8888);
    check("t1 valid_o", valid_o, 8'h80);
    check("t1 a_o held", a_o, 16'h1111);

    // stall channel 2, isolation on channel 5, then pass-through on release
    drive(1'b1, 3'd2, 16'hAAAA, 8'hFB);
    drive(1'b1, 3'd5, 16'h5A5A, 8'hFB);
    @(negedge clk_i);
    check("t2 valid_o", valid_o, 8'h04);
    check("t2 c_o", c_o, 16'hAAAA);
    drive(1'b1, 3'd2, 16'hBBBB, 8'hFB);
    @(negedge clk_i);
    check("t3 f_o", f_o, 16'h5A5A);
    check("t3 c_o", c_o, 16'hAAAA);
    check("t2 ready_o stalled", ready_o, 1'b0);
    step();
    @(negedge clk_i);
    check("t2 still stalled", ready_o, 1'b0);
    check("t2 valid_o held", valid_o, 8'h04);
    drive(1'b1, 3'd2, 16'hBBBB, 8'hFF);
    @(negedge clk_i);
    check("t2 ready_o released", ready_o, 1'b1);
    drive(1'b0, 3'd2, 16'h0, 8'hFF);
    @(negedge clk_i);
    check("t2 c_o pass-through", c_o, 16'hBBBB);
    check("t2 valid_o after", valid_o, 8'h04);
    check("t2 count_o", count_o, 16'd11);

    // random traffic
    for (int i = 0; i < 3000; i++) drive_random();

    // back-to-back to channel 7
    reset_dut();
    for (int i = 0; i < 20; i++) drive(1'b1, 3'd7, 16'($urandom), 8'hFF);
    drive(1'b0, 3'd0, 16'h0, 8'hFF);
    @(negedge clk_i);
    check("t4 count_o", count_o, 16'd20);

    // reset mid-operation with channels 0, 3, 6 stalled
    drive(1'b1, 3'd0, 16'hC0C0, 8'hB6);
    drive(1'b1, 3'd3, 16'hC3C3, 8'hB6);
    drive(1'b1, 3'd6, 16'hC6C6, 8'hB6);
    drive(1'b0, 3'd0, 16'h0, 8'hB6);
    @(negedge clk_i);
    check("t5 valid_o before", valid_o, 8'h49);
    step();
    rst_i = 1'b0; valid_i = 1'b1; sel_i = 3'd1; data_i = 16'hDEAD; ready_i = 8'hFF;
    step();
    rst_i = 1'b1; valid_i = 1'b0;
    @(negedge clk_i);
    check("t5 valid_o", valid_o, 8'h00);
    check("t5 count_o", count_o, 16'h0000);
    check("t5 ready_o", ready_o, 1'b1);
    check("t5 d_o", d_o, 16'h0000);
    check("t5 g_o", g_o, 16'h0000);

    // count wrap
    reset_dut();
    for (int i = 0; i < 65535; i++) drive(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 8'hFF);
    step();
    @(negedge clk_i);
    check("t6 count_o max", count_o, 16'hFFFF);
    drive(1'b0, 3'd0, 16'h0, 8'hFF);
    @(negedge clk_i);
    check("t6 count_o wrap", count_o, 16'h0000);

    step();
    @(negedge clk_i);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux8_16.md
# demux8_16

Registered 1-to-8 demultiplexer with valid/ready flow control. It is the opposite direction of the 8-to-1 registered mux: one input stream carries a 3-bit route select, and each word is delivered to exactly one of eight output channels. Each channel has a single-entry holding register, so independent downstream consumers can stall without blocking traffic to the other channels. It sits between a shared producer and eight lane consumers in the datapath.

## Interface
- Width, 16, data width of input and every output channel.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- sel_i  input  3  destination channel for the current input word (0=a … 7=h).
- data_i  input  Width  input word.
- valid_i  input  1  input word and sel_i are valid.
- ready_o  output  1  block accepts the input word this cycle.
- a_o … h_o  output  Width each  channel 0…7 data.
- valid_o  output  8  bit n set while channel n holds a word.
- ready_i  input  8  bit n set while consumer n accepts.
- count_o  output  16  number of accepted input words, wraps modulo 2^16.

## Operation
- Input handshake: a word is accepted when valid_i && ready_o on a rising edge.
- ready_o = !valid_o[sel_i] || ready_i[sel_i]. It is combinational in sel_i, valid_o and ready_i, and independent of valid_i.
- Output handshake on channel n: the held word is consumed when valid_o[n] && ready_i[n].
- Per-channel slot states:
  - EMPTY: valid_o[n]=0.
    - Accepted word with sel_i=n → FULL, and the channel data register loads data_i.
  - FULL: valid_o[n]=1.
    - Consumed with no new word for n → EMPTY.
    - Consumed and a new word for n accepted in the same cycle → stays FULL, and the data register loads the new word (pass-through at full throughput).
    - Not consumed → holds, and ready_o=0 whenever sel_i=n.
- Only the selected channel changes on an accept. All other channels are unaffected by sel_i and data_i.
- Channel data registers hold their last value after the word is consumed. Consumers qualify data with valid_o only.
- count_o increments by 1 on every accepted word and wraps from 0xFFFF to 0x0000.
- valid_i=0 with any sel_i and data_i: no state change except consumption.
- sel_i and data_i may change freely while valid_i=0.
- While valid_i=1 and ready_o=0, the producer holds sel_i and data_i stable. The block does not check this.

## Timing
- Latency: a word accepted at edge k is visible on its channel with valid_o[n]=1 after edge k, so it can be consumed at edge k+1.
- Throughput: one word per cycle, including repeated traffic to a single channel whose consumer holds ready_i high.
- Reset (rst_i=0 at a rising edge):
  - a_o…h_o=0, valid_o=8'h00, count_o=0.
  - ready_o is therefore 1 from the first cycle after reset.
  - Reset takes priority over any simultaneous accept or consume.
  - Held words are discarded when reset is asserted mid-operation.
- Simultaneous events:
  - A consume on channel m and an accept for channel n≠m in the same cycle are both performed.
  - For n=m, see the FULL pass-through rule in Operation.
- Backpressure:
  - Stalling consumer n blocks only inputs with sel_i=n.
  - The producer must not reorder its words. A stalled head word blocks the input interface as a whole.
- No combinational path from valid_i to ready_o. There is a combinational path from ready_i and sel_i to ready_o.

## Structure
- Shared package demux_pkg:
  - NumChannels=8, SelWidth=3, CountWidth=16.
  - typedef sel_t (logic [SelWidth-1:0]).
  - The channel index constants are shared with the mux testbench.
- Sub-module demux_slot, parameterised by Width:
  - Ports: load, consume, data in; data out and valid out.
  - Implements the EMPTY/FULL register and its reset.
- The top level instantiates eight demux_slot instances, decodes sel_i into the eight load strobes, generates ready_o, and holds count_o.

## Test plan
1. Reset, then one word per channel: sel_i=0…7 with data_i=16'h1111…16'h8888, all ready_i=8'hFF → each x_o shows its value with a one-cycle valid_o pulse on its bit, and count_o=8.
2. Stall channel 2: ready_i=8'hFB, send 16'hAAAA then 16'hBBBB to sel_i=2 → the first word is held, ready_o=0 for the second, and c_o=16'hAAAA. Raise ready_i[2] → 16'hAAAA is consumed and 16'hBBBB is accepted in the same cycle.
3. Isolation: channel 2 stalled and full, send 16'h5A5A to sel_i=5 → accepted, f_o=16'h5A5A, and c_o is unchanged.
4. Back-to-back to channel 7 with ready_i[7]=1 for 20 cycles of valid_i=1 → 20 words are delivered in order at one per cycle, and count_o=20.
5. Reset mid-operation with channels 0, 3 and 6 full and stalled, rst_i=0 for one cycle → valid_o=8'h00, all x_o=0, count_o=0, and ready_o=1 on the next cycle.
6. Wrap: preload 65535 accepts (or drive the slot through a long run), then one more accept → count_o goes 0xFFFF → 0x0000.
